// File: rtl/stage_pre_if_pkg.sv
// Shared types and constants for the pre-IF fetch stage.
package stage_pre_if_pkg;

  localparam int               WIDTH        = 32;
  localparam logic [WIDTH-1:0] RESET_PC_DEF = 32'h1c000000;
  localparam logic [1:0]       SZ_WORD      = 2'd2;

  // Outstanding and discard counters are 2 bits wide.
  localparam int               CNT_W        = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } pre_if_state_e;

  // Pending redirect captured while a request waits on addr_ok.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] pc;
  } br_buf_t;

  // Sequential fetch advance, wrapping at 32 bits.
  function automatic logic [WIDTH-1:0] next_seq_pc(input logic [WIDTH-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pre_if_req_tracker.sv
// Counts accepted-but-unanswered requests and the responses still to be
// dropped, and filters data_ok so squashed fetches never reach IF.
module pre_if_req_tracker
  import stage_pre_if_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             accept,       // request accepted (req && addr_ok)
  input  logic             discard,      // an accepted request was squashed
  input  logic             data_ok,
  output logic [CNT_W-1:0] outstanding,
  output logic [CNT_W-1:0] discard_cnt,
  output logic             can_issue,
  output logic             if_data_ok
);

  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DISC_FULL = '1;

  logic             drop;
  logic [CNT_W-1:0] out_nxt;
  logic [CNT_W-1:0] disc_nxt;

  // Responses return in order, so the oldest ones are the squashed ones.
  assign drop       = data_ok && (discard_cnt != '0);
  assign if_data_ok = data_ok && (discard_cnt == '0);

  // A response arriving this cycle frees its slot for a new request.
  assign can_issue  = ((outstanding < MAX_CNT) || data_ok) && (discard_cnt != DISC_FULL);

  // Next outstanding count; simultaneous accept and response cancel out.
  always_comb begin
    out_nxt = outstanding;
    case ({accept, data_ok})
      2'b10:   out_nxt = outstanding + CNT_ONE;
      2'b01:   out_nxt = outstanding - CNT_ONE;
      default: out_nxt = outstanding;
    endcase
  end

  // Next discard count; simultaneous squash and drop cancel out.
  always_comb begin
    disc_nxt = discard_cnt;
    case ({discard, drop})
      2'b10:   disc_nxt = discard_cnt + CNT_ONE;
      2'b01:   disc_nxt = discard_cnt - CNT_ONE;
      default: disc_nxt = discard_cnt;
    endcase
  end

  // Counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      outstanding <= out_nxt;
      discard_cnt <= disc_nxt;
    end
  end

endmodule

// File: rtl/stage_pre_if.sv
// Pre-IF stage: owns the fetch PC, issues SRAM-like instruction requests,
// hands accepted fetches to IF and applies EX branch redirects.
module stage_pre_if
  import stage_pre_if_pkg::*;
#(
  parameter logic [WIDTH-1:0] RESET_PC        = RESET_PC_DEF,
  parameter int               MAX_OUTSTANDING = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             if_allowin,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  output logic             inst_sram_req,
  output logic             inst_sram_wr,
  output logic [1:0]       inst_sram_size,
  output logic [WIDTH-1:0] inst_sram_addr,
  input  logic             inst_sram_addr_ok,
  input  logic             inst_sram_data_ok,
  output logic             pre_if_to_if_valid,
  output logic [WIDTH-1:0] pre_if_pc,
  output logic             if_data_ok
);

  pre_if_state_e    state, state_nxt;
  logic [WIDTH-1:0] fetch_pc;
  br_buf_t          br_buf;
  logic             stale;

  logic             accept;
  logic             handoff;
  logic             discard;
  logic             can_issue;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard_cnt;

  assign accept             = (state == ST_REQ) && inst_sram_addr_ok;
  assign pre_if_to_if_valid = (accept || (state == ST_WAIT)) && !stale && !br_taken;
  assign handoff            = pre_if_to_if_valid && if_allowin;

  // An accepted request whose response IF must never see: either it was
  // redirected while waiting on addr_ok, or a branch hits it on/after accept.
  assign discard = (accept && (stale || br_taken)) || ((state == ST_WAIT) && br_taken);

  assign inst_sram_req  = (state == ST_REQ);
  assign inst_sram_wr   = 1'b0;
  assign inst_sram_size = SZ_WORD;
  assign inst_sram_addr = fetch_pc;
  assign pre_if_pc      = fetch_pc;

  pre_if_req_tracker #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_trk (
    .clk         (clk),
    .resetn      (resetn),
    .accept      (accept),
    .discard     (discard),
    .data_ok     (inst_sram_data_ok),
    .outstanding (outstanding),
    .discard_cnt (discard_cnt),
    .can_issue   (can_issue),
    .if_data_ok  (if_data_ok)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; a raised req only leaves REQ through addr_ok.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (can_issue) state_nxt = ST_REQ;
      ST_REQ:  if (inst_sram_addr_ok)
                 state_nxt = (pre_if_to_if_valid && !if_allowin) ? ST_WAIT : ST_IDLE;
      ST_WAIT: if (if_allowin || br_taken) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Fetch PC, redirect buffer and stale flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc <= RESET_PC;
      br_buf   <= '{valid: 1'b0, pc: RESET_PC};
      stale    <= 1'b0;
    end else if (handoff) begin
      fetch_pc     <= br_buf.valid ? br_buf.pc : next_seq_pc(fetch_pc);
      br_buf.valid <= 1'b0;
    end else if (br_taken && ((state != ST_REQ) || inst_sram_addr_ok)) begin
      // IDLE, WAIT, or REQ accepted this cycle: redirect immediately. A
      // stale request accepted alongside a new branch takes the newest target.
      fetch_pc     <= br_target;
      br_buf.valid <= 1'b0;
      stale        <= 1'b0;
    end else if (br_taken) begin
      // REQ still waiting: req/addr must hold, so park the target.
      br_buf <= '{valid: 1'b1, pc: br_target};
      stale  <= 1'b1;
    end else if (accept && stale) begin
      fetch_pc     <= br_buf.pc;
      br_buf.valid <= 1'b0;
      stale        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stage_pre_if.sv
// Scenario bench for stage_pre_if with a handoff/response scoreboard.
module tb_stage_pre_if;
  import stage_pre_if_pkg::*;

  localparam logic [31:0] RPC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        if_allowin = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic        pre_if_to_if_valid;
  logic [31:0] pre_if_pc;
  logic        if_data_ok;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] exp_pc[$];
  logic        exp_dok[$];

  stage_pre_if dut (
    .clk                (clk),
    .resetn             (resetn),
    .if_allowin         (if_allowin),
    .br_taken           (br_taken),
    .br_target          (br_target),
    .inst_sram_req      (inst_sram_req),
    .inst_sram_wr       (inst_sram_wr),
    .inst_sram_size     (inst_sram_size),
    .inst_sram_addr     (inst_sram_addr),
    .inst_sram_addr_ok  (inst_sram_addr_ok),
    .inst_sram_data_ok  (inst_sram_data_ok),
    .pre_if_to_if_valid (pre_if_to_if_valid),
    .pre_if_pc          (pre_if_pc),
    .if_data_ok         (if_data_ok)
  );

  always #5 clk = ~clk;

  // Scoreboard: every handoff and every response is matched against the
  // next expectation pushed by the scenario that drove it.
  always @(negedge clk) begin
    #2;
    if (resetn) begin
      if (pre_if_to_if_valid && if_allowin) begin
        n_chk++;
        if (exp_pc.size() == 0) begin
          n_fail++;
          $display("FAIL sb_handoff: got pc %h, expected no handoff", pre_if_pc);
        end else begin
          logic [31:0] e;
          e = exp_pc.pop_front();
          if (pre_if_pc !== e) begin
            n_fail++;
            $display("FAIL sb_handoff: got pc %h, expected %h", pre_if_pc, e);
          end
        end
      end
      if (inst_sram_data_ok) begin
        n_chk++;
        if (exp_dok.size() == 0) begin
          n_fail++;
          $display("FAIL sb_data_ok: got if_data_ok %b, no response expected", if_data_ok);
        end else begin
          logic e;
          e = exp_dok.pop_front();
          if (if_data_ok !== e) begin
            n_fail++;
            $display("FAIL sb_data_ok: got if_data_ok %b, expected %b", if_data_ok, e);
          end
        end
      end
    end
  end

  // One cycle of stimulus, applied at the falling edge; returns 1ns later.
  task automatic drive(input logic al, input logic aok, input logic dok,
                       input logic br = 1'b0, input logic [31:0] tgt = '0);
    @(negedge clk);
    if_allowin        = al;
    inst_sram_addr_ok = aok;
    inst_sram_data_ok = dok;
    br_taken          = br;
    br_target         = tgt;
    #1;
  endtask

  // Reset pulse; first confirms the previous scenario consumed everything.
  task automatic do_reset();
    @(negedge clk);
    n_chk++;
    if (exp_pc.size() != 0 || exp_dok.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d handoffs / %0d responses pending, expected 0/0",
               exp_pc.size(), exp_dok.size());
    end
    exp_pc.delete();
    exp_dok.delete();
    resetn = 1'b0;
    if_allowin = 1'b0; inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
    br_taken = 1'b0; br_target = '0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    #1;
    n_chk++; if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", inst_sram_req); end
    n_chk++; if (pre_if_to_if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", pre_if_to_if_valid); end
    n_chk++; if (if_data_ok !== 1'b0) begin n_fail++; $display("FAIL rst_dok: got %b expected 0", if_data_ok); end
    n_chk++; if (pre_if_pc !== RPC) begin n_fail++; $display("FAIL rst_pc: got %h expected %h", pre_if_pc, RPC); end
    n_chk++; if (inst_sram_wr !== 1'b0 || inst_sram_size !== 2'd2) begin n_fail++; $display("FAIL rst_wr_size: got %b/%0d expected 0/2", inst_sram_wr, inst_sram_size); end
    n_chk++; if (dut.u_trk.outstanding !== 2'd0 || dut.u_trk.discard_cnt !== 2'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", dut.u_trk.outstanding, dut.u_trk.discard_cnt); end
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_pc.push_back(RPC + 32'(4 * i));
      drive(1'b1, 1'b1, 1'b0);
      n_chk++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== RPC + 32'(4 * i)) begin n_fail++; $display("FAIL stream_req%0d: got %b@%h expected 1@%h", i, inst_sram_req, inst_sram_addr, RPC + 32'(4 * i)); end
      n_chk++; if (pre_if_to_if_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid%0d: got %b expected 1", i, pre_if_to_if_valid); end
      exp_dok.push_back(1'b1);
      drive(1'b1, 1'b0, 1'b1);
      n_chk++; if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL stream_idle%0d: got req %b expected 0", i, inst_sram_req); end
    end
  endtask

  task automatic test_addr_stall();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      n_chk++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== RPC || pre_if_to_if_valid !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d: got req %b addr %h valid %b expected 1 %h 0", i, inst_sram_req, inst_sram_addr, pre_if_to_if_valid, RPC); end
    end
    exp_pc.push_back(RPC);
    drive(1'b1, 1'b1, 1'b0);
    n_chk++; if (pre_if_to_if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_accept: got valid %b expected 1", pre_if_to_if_valid); end
    exp_dok.push_back(1'b1);
    drive(1'b0, 1'b0, 1'b1);
    n_chk++; if (dut.u_trk.outstanding !== 2'd1) begin n_fail++; $display("FAIL stall_outstanding: got %0d expected 1", dut.u_trk.outstanding); end
  endtask

  task automatic test_branch_stall();
    do_reset();
    exp_pc.push_back(RPC);       drive(1'b1, 1'b1, 1'b0);
    exp_dok.push_back(1'b1);     drive(1'b1, 1'b0, 1'b1);
    exp_pc.push_back(RPC + 4);   drive(1'b1, 1'b1, 1'b0);
    exp_dok.push_back(1'b1);     drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, RPC + 32'h100);
    n_chk++; if (inst_sram_addr !== RPC + 8 || pre_if_to_if_valid !== 1'b0) begin n_fail++; $display("FAIL brs_redirect: got addr %h valid %b expected %h 0", inst_sram_addr, pre_if_to_if_valid, RPC + 8); end
    drive(1'b1, 1'b0, 1'b0);
    n_chk++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== RPC + 8) begin n_fail++; $display("FAIL brs_hold: got %b@%h expected 1@%h", inst_sram_req, inst_sram_addr, RPC + 8); end
    drive(1'b1, 1'b1, 1'b0);
    n_chk++; if (pre_if_to_if_valid !== 1'b0) begin n_fail++; $display("FAIL brs_stale_accept: got valid %b expected 0", pre_if_to_if_valid); end
    drive(1'b1, 1'b0, 1'b0);
    n_chk++; if (dut.u_trk.discard_cnt !== 2'd1) begin n_fail++; $display("FAIL brs_discard: got %0d expected 1", dut.u_trk.discard_cnt); end
    exp_pc.push_back(RPC + 32'h100); exp_dok.push_back(1'b0);
    drive(1'b1, 1'b1, 1'b1);
    n_chk++; if (inst_sram_addr !== RPC + 32'h100) begin n_fail++; $display("FAIL brs_target: got %h expected %h", inst_sram_addr, RPC + 32'h100); end
    n_chk++; if (if_data_ok !== 1'b0) begin n_fail++; $display("FAIL brs_suppress: got %b expected 0", if_data_ok); end
    exp_dok.push_back(1'b1);
    drive(1'b1, 1'b0, 1'b1);
    n_chk++; if (if_data_ok !== 1'b1) begin n_fail++; $display("FAIL brs_pass: got %b expected 1", if_data_ok); end
  endtask

  task automatic test_double_branch();
    do_reset();
    exp_pc.push_back(RPC);   drive(1'b1, 1'b1, 1'b0);
    exp_dok.push_back(1'b1); drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, RPC + 32'h200);
    drive(1'b1, 1'b0, 1'b0, 1'b1, RPC + 32'h300);
    n_chk++; if (inst_sram_addr !== RPC + 4) begin n_fail++; $display("FAIL dbl_hold: got %h expected %h", inst_sram_addr, RPC + 4); end
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    n_chk++; if (dut.u_trk.discard_cnt !== 2'd1 || dut.u_trk.outstanding !== 2'd1) begin n_fail++; $display("FAIL dbl_cnt: got %0d/%0d expected 1/1", dut.u_trk.discard_cnt, dut.u_trk.outstanding); end
    exp_pc.push_back(RPC + 32'h300); exp_dok.push_back(1'b0);
    drive(1'b1, 1'b1, 1'b1);
    n_chk++; if (inst_sram_addr !== RPC + 32'h300) begin n_fail++; $display("FAIL dbl_latest: got %h expected %h", inst_sram_addr, RPC + 32'h300); end
    exp_dok.push_back(1'b1);
    drive(1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_wait_backpressure();
    do_reset();
    drive(1'b0, 1'b1, 1'b0);
    n_chk++; if (pre_if_to_if_valid !== 1'b1) begin n_fail++; $display("FAIL wait_enter: got valid %b expected 1", pre_if_to_if_valid); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      n_chk++; if (pre_if_to_if_valid !== 1'b1 || pre_if_pc !== RPC || inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL wait_hold%0d: got valid %b pc %h req %b expected 1 %h 0", i, pre_if_to_if_valid, pre_if_pc, inst_sram_req, RPC); end
    end
    exp_pc.push_back(RPC); drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    n_chk++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== RPC + 4) begin n_fail++; $display("FAIL wait_req2: got %b@%h expected 1@%h", inst_sram_req, inst_sram_addr, RPC + 4); end
    exp_pc.push_back(RPC + 4); drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      n_chk++; if (inst_sram_req !== 1'b0 || dut.u_trk.outstanding !== 2'd2) begin n_fail++; $display("FAIL wait_full%0d: got req %b outstanding %0d expected 0 2", i, inst_sram_req, dut.u_trk.outstanding); end
    end
    exp_dok.push_back(1'b1); drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    n_chk++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== RPC + 8) begin n_fail++; $display("FAIL wait_resume: got %b@%h expected 1@%h", inst_sram_req, inst_sram_addr, RPC + 8); end
    exp_dok.push_back(1'b1); drive(1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_branch_on_accept();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b1, RPC + 32'h400);
    n_chk++; if (pre_if_to_if_valid !== 1'b0) begin n_fail++; $display("FAIL bra_drop: got valid %b expected 0", pre_if_to_if_valid); end
    drive(1'b1, 1'b0, 1'b0);
    n_chk++; if (dut.u_trk.discard_cnt !== 2'd1) begin n_fail++; $display("FAIL bra_discard: got %0d expected 1", dut.u_trk.discard_cnt); end
    drive(1'b0, 1'b1, 1'b0);
    n_chk++; if (inst_sram_addr !== RPC + 32'h400) begin n_fail++; $display("FAIL bra_target: got %h expected %h", inst_sram_addr, RPC + 32'h400); end
    drive(1'b0, 1'b0, 1'b0, 1'b1, RPC + 32'h500);
    n_chk++; if (pre_if_to_if_valid !== 1'b0) begin n_fail++; $display("FAIL bra_wait_drop: got valid %b expected 0", pre_if_to_if_valid); end
    exp_dok.push_back(1'b0); drive(1'b1, 1'b0, 1'b1);
    n_chk++; if (dut.u_trk.discard_cnt !== 2'd2) begin n_fail++; $display("FAIL bra_discard2: got %0d expected 2", dut.u_trk.discard_cnt); end
    exp_dok.push_back(1'b0); drive(1'b1, 1'b0, 1'b1);
    n_chk++; if (inst_sram_addr !== RPC + 32'h500) begin n_fail++; $display("FAIL bra_target2: got %h expected %h", inst_sram_addr, RPC + 32'h500); end
    exp_pc.push_back(RPC + 32'h500); drive(1'b1, 1'b1, 1'b0);
    exp_dok.push_back(1'b1);          drive(1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_idle_branch_wrap();
    do_reset();
    exp_pc.push_back(RPC);   drive(1'b1, 1'b1, 1'b0);
    exp_dok.push_back(1'b1); drive(1'b1, 1'b0, 1'b1, 1'b1, 32'hfffffffc);
    exp_pc.push_back(32'hfffffffc);
    drive(1'b1, 1'b1, 1'b0);
    n_chk++; if (inst_sram_addr !== 32'hfffffffc || dut.u_trk.discard_cnt !== 2'd0) begin n_fail++; $display("FAIL idle_br: got %h disc %0d expected fffffffc 0", inst_sram_addr, dut.u_trk.discard_cnt); end
    exp_dok.push_back(1'b1); drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    n_chk++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h0) begin n_fail++; $display("FAIL wrap: got %b@%h expected 1@00000000", inst_sram_req, inst_sram_addr); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    n_chk++; if (pre_if_to_if_valid !== 1'b1) begin n_fail++; $display("FAIL mid_wait: got valid %b expected 1", pre_if_to_if_valid); end
    #3 resetn = 1'b0;
    #1;
    n_chk++; if (inst_sram_req !== 1'b0 || pre_if_to_if_valid !== 1'b0 || pre_if_pc !== RPC) begin n_fail++; $display("FAIL mid_rst_out: got req %b valid %b pc %h expected 0 0 %h", inst_sram_req, pre_if_to_if_valid, pre_if_pc, RPC); end
    n_chk++; if (dut.u_trk.outstanding !== 2'd0 || dut.u_trk.discard_cnt !== 2'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d/%0d expected 0/0", dut.u_trk.outstanding, dut.u_trk.discard_cnt); end
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    n_chk++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== RPC) begin n_fail++; $display("FAIL mid_restart: got %b@%h expected 1@%h", inst_sram_req, inst_sram_addr, RPC); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_addr_stall();
    test_branch_stall();
    test_double_branch();
    test_wait_backpressure();
    test_branch_on_accept();
    test_idle_branch_wrap();
    test_reset_mid_wait();
    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
